// File: rtl/shift_add_multiplier_5_bit_pkg.sv
// Shared widths, iteration count, state encoding and product payload for the 5-bit shift-add multiplier.
package shift_add_multiplier_5_bit_pkg;

   localparam int unsigned OP_W   = 5;
   localparam int unsigned PROD_W = 10;
   localparam int unsigned ITER_N = 5;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned SUM_W  = OP_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Accumulator high half and multiplier/low half viewed as one product-wide word.
   typedef struct packed {
      logic [OP_W-1:0] hi;
      logic [OP_W-1:0] lo;
   } prod_t;

   // True when the given count is the final shift-add iteration.
   function automatic logic last_iter(input logic [CNT_W-1:0] cnt);
      return cnt == CNT_W'(ITER_N - 1);
   endfunction

endpackage

// File: rtl/shift_add_multiplier_5_bit_adder.sv
// 5-bit ripple-style adder with carry in/out; the only adder in the multiplier.
module Adder_5_bit
   import shift_add_multiplier_5_bit_pkg::*;
(
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   input  logic            cin,
   output logic [OP_W-1:0] sum_c,
   output logic            cout_c
);

   // Full-width sum so the carry-out is preserved.
   assign {cout_c, sum_c} = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);

endmodule

// File: rtl/shift_add_multiplier_5_bit.sv
// Sequential 5x5 unsigned shift-add multiplier: one add-and-shift per cycle, product published on DONE.
module shift_add_multiplier_5_bit
   import shift_add_multiplier_5_bit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OP_W-1:0]   A,
   input  logic [OP_W-1:0]   B,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] P
);

   state_t             state_q, state_d;
   logic [OP_W-1:0]    mcand_q, mcand_d;
   logic [OP_W-1:0]    mplier_q, mplier_d;
   logic [OP_W-1:0]    acc_hi_q, acc_hi_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PROD_W-1:0]  p_d;
   logic               busy_d, done_d;

   logic [OP_W-1:0]    addend_c;
   logic [OP_W-1:0]    sum_c;
   logic               cout_c;
   prod_t              shifted_c;

   // Add the multiplicand only when the current multiplier LSB is set.
   assign addend_c = mplier_q[0] ? mcand_q : '0;

   Adder_5_bit u_adder (
      .a      (acc_hi_q),
      .b      (addend_c),
      .cin    (1'b0),
      .sum_c  (sum_c),
      .cout_c (cout_c)
   );

   // Carry shifts into the top of the accumulator; the sum LSB drops into the multiplier half.
   assign shifted_c = prod_t'({cout_c, sum_c, mplier_q[OP_W-1:1]});

   // State and datapath registers; reset clears everything including the published product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_hi_q <= '0;
         cnt_q    <= '0;
         P        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_hi_q <= acc_hi_d;
         cnt_q    <= cnt_d;
         P        <= p_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   // Next-state and next-output logic; registered busy/done track the state being entered.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_hi_d = acc_hi_q;
      cnt_d    = cnt_q;
      p_d      = P;
      busy_d   = busy;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = A;
               mplier_d = B;
               acc_hi_d = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = CALC;
            end
         end
         CALC: begin
            acc_hi_d = shifted_c.hi;
            mplier_d = shifted_c.lo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_iter(cnt_q)) begin
               p_d     = PROD_W'(shifted_c);
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_add_multiplier_5_bit.sv
// Scoreboard bench for the shift-add multiplier: stimulus pushes A*B, a negedge monitor pops on done.
module tb_shift_add_multiplier_5_bit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [4:0] A;
   logic [4:0] B;
   logic       busy;
   logic       done;
   logic [9:0] P;

   int passed;
   int total;
   int exp_q[$];
   logic [9:0] prev_p;
   logic       prev_rstn;

   shift_add_multiplier_5_bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   // Monitor: every done pulse must pair with the oldest outstanding expected product.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            check("product", int'(P), exp_q.pop_front());
         end
      end
      if (rst_n && prev_rstn && (P != prev_p)) check("p_changes_only_with_done", int'(done), 1);
      prev_p    = P;
      prev_rstn = rst_n;
   end

   // One full multiply from IDLE: acceptance, 5-edge latency, single done pulse, return to idle.
   task automatic run_op(input logic [4:0] a, input logic [4:0] b, input bit scramble);
      A     = a;
      B     = b;
      start = 1'b1;
      exp_q.push_back(int'(a) * int'(b));
      @(posedge clk); #1;
      check("accept_busy", int'(busy), 1);
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (scramble) begin
            A     = 5'($urandom);
            B     = 5'($urandom);
            start = 1'($urandom);
         end
         @(posedge clk); #1;
         check("done_timing", int'(done), (k == 5) ? 1 : 0);
         check("busy_timing", int'(busy), (k < 6) ? 1 : 0);
      end
      start = 1'b0;
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      prev_p    = '0;
      prev_rstn = 1'b0;
      rst_n     = 1'b0;
      start     = 1'b0;
      A         = '0;
      B         = '0;

      // Reset state
      #1;
      check("rst_p", int'(P), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed operand pairs including the maximum
      run_op(5'd31, 5'd31, 1'b0);
      check("max_product_held", int'(P), 961);
      run_op(5'd21, 5'd10, 1'b0);
      run_op(5'd0,  5'd27, 1'b0);
      run_op(5'd1,  5'd1,  1'b0);

      // Start held high: one product every 7 edges, no acceptance while busy
      A     = 5'd3;
      B     = 5'd5;
      start = 1'b1;
      for (int n = 0; n < 3; n++) begin
         exp_q.push_back(15);
         @(posedge clk); #1;
         check("held_accept_busy", int'(busy), 1);
         for (int k = 1; k <= 6; k++) begin
            if (k == 6) start = (n == 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            check("held_done", int'(done), (k == 5) ? 1 : 0);
            check("held_busy", int'(busy), (k < 6) ? 1 : 0);
         end
      end
      start = 1'b0;

      // Operands and start toggling during CALC must not disturb the result
      run_op(5'd7, 5'd9, 1'b1);

      // Reset in the third CALC cycle aborts the operation
      A     = 5'd17;
      B     = 5'd19;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_p", int'(P), 0);
      check("abort_done", int'(done), 0);
      check("abort_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         check("abort_no_done", int'(done), 0);
      end
      run_op(5'd12, 5'd13, 1'b0);

      // Random operands with random scrambling during CALC
      for (int n = 0; n < 40; n++) begin
         run_op(5'($urandom), 5'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      // Exhaustive sweep
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            run_op(5'(a), 5'(b), 1'b0);
         end
      end

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
